minterm_scan_ctrl: RTL and testbench

MINTERM_SCAN_CTRL -- requirements
Module: minterm_scan_ctrl

---
 rtl/minterm_scan_ctrl.sv | 100 ++++++++++
 tb/tb_minterm_scan_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/minterm_scan_ctrl.sv
// Walks a 4-input function through all 16 minterms, captures its truth table and compares against a golden copy.
// Each minterm is held SETTLE cycles before f_in is sampled; done pulses 16*SETTLE+1 edges after start.
module minterm_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic [3:0]  m_out,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [15:0] tt,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail,
  output logic        pass
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state;
  logic [3:0]  settle_cnt;
  logic [15:0] exp_q;
  logic        sample_edge;
  logic        miss;

  // The sample edge is the one on which the settle counter would reach zero.
  assign sample_edge = (settle_cnt == 4'd1);
  assign miss        = (f_in != exp_q[m_out]);
  assign pass        = valid && (mismatch_cnt == 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      m_out        <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      valid        <= 1'b0;
      tt           <= 16'd0;
      mismatch_cnt <= 5'd0;
      first_fail   <= 4'd0;
      settle_cnt   <= 4'd0;
      exp_q        <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= SCAN;
            busy         <= 1'b1;
            m_out        <= 4'd0;
            valid        <= 1'b0;
            tt           <= 16'd0;
            mismatch_cnt <= 5'd0;
            first_fail   <= 4'd0;
            exp_q        <= expected;
            settle_cnt   <= SETTLE_LD;
          end
        end
        SCAN: begin
          if (abort) begin
            // Partial tt/mismatch_cnt are left visible; valid stays low.
            state      <= IDLE;
            busy       <= 1'b0;
            m_out      <= 4'd0;
            settle_cnt <= 4'd0;
          end else if (sample_edge) begin
            tt[m_out] <= f_in;
            if (miss) begin
              mismatch_cnt <= mismatch_cnt + 5'd1;
              if (mismatch_cnt == 5'd0) first_fail <= m_out;
            end
            if (m_out == 4'd15) begin
              state      <= DONE;
              settle_cnt <= 4'd0;
            end else begin
              m_out      <= m_out + 4'd1;
              settle_cnt <= SETTLE_LD;
            end
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_scan_ctrl.sv
// Bench for minterm_scan_ctrl: one instance with SETTLE=1 on a SoP function, one with SETTLE=3 on a constant-0 function.
module tb_minterm_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] expected = 16'd0;
  logic        f3_val = 1'b0;

  logic        start1, start3, abort1, abort3, f_in1, f_in3;
  logic [3:0]  m_out1, m_out3, ff1, ff3;
  logic        busy1, busy3, done1, done3, valid1, valid3, pass1, pass3;
  logic [15:0] tt1, tt3;
  logic [4:0]  cnt1, cnt3;

  logic [3:0]  mo, ff;
  logic        bz, dn, vl, ps;
  logic [15:0] tv;
  logic [4:0]  mc;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  cnt;
    logic [3:0]  ff;
    logic        pass;
  } res_t;

  res_t sbq[$];

  always #5 clk = ~clk;

  assign start1 = start & ~sel;
  assign start3 = start & sel;
  assign abort1 = abort & ~sel;
  assign abort3 = abort & sel;
  assign f_in1  = (m_out1[3] & ~m_out1[2] & m_out1[1]) | (m_out1[3] & m_out1[2] & ~m_out1[1]);
  assign f_in3  = f3_val;

  assign mo = sel ? m_out3 : m_out1;
  assign bz = sel ? busy3  : busy1;
  assign dn = sel ? done3  : done1;
  assign vl = sel ? valid3 : valid1;
  assign tv = sel ? tt3    : tt1;
  assign mc = sel ? cnt3   : cnt1;
  assign ff = sel ? ff3    : ff1;
  assign ps = sel ? pass3  : pass1;

  minterm_scan_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(expected), .f_in(f_in1),
    .m_out(m_out1), .busy(busy1), .done(done1), .valid(valid1), .tt(tt1),
    .mismatch_cnt(cnt1), .first_fail(ff1), .pass(pass1)
  );

  minterm_scan_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .expected(expected), .f_in(f_in3),
    .m_out(m_out3), .busy(busy3), .done(done3), .valid(valid3), .tt(tt3),
    .mismatch_cnt(cnt3), .first_fail(ff3), .pass(pass3)
  );

  function automatic logic sop(input logic [3:0] m);
    return (m[3] & ~m[2] & m[1]) | (m[3] & m[2] & ~m[1]);
  endfunction

  function automatic res_t model(input logic s, input logic [15:0] e);
    res_t r;
    logic fk;
    r.tt = 16'd0; r.cnt = 5'd0; r.ff = 4'd0;
    for (int k = 0; k < 16; k++) begin
      fk = s ? 1'b0 : sop(k[3:0]);
      r.tt[k] = fk;
      if (fk != e[k]) begin
        if (r.cnt == 5'd0) r.ff = k[3:0];
        r.cnt = r.cnt + 5'd1;
      end
    end
    r.pass = (r.cnt == 5'd0);
    return r;
  endfunction

  task automatic run_scan(input logic s, input logic [15:0] e, input bit restart_mid,
                          input bit abort_with_start, input bit scramble_exp);
    int   st;
    int   last;
    res_t r;
    st   = s ? 3 : 1;
    last = 16 * st + 1;
    @(negedge clk);
    sel = s; expected = e; start = 1'b1; abort = abort_with_start;
    sbq.push_back(model(s, e));
    @(posedge clk);
    for (int n = 0; n <= last + 2; n++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (scramble_exp) expected = ~e;
      if (restart_mid && n == 4) start = 1'b1;
      if (n == 0) begin
        tests++;
        if (bz !== 1'b1 || vl !== 1'b0 || tv !== 16'd0 || mc !== 5'd0) begin
          fails++;
          $display("FAIL start_state: busy=%b valid=%b tt=%h cnt=%0d, want 1 0 0000 0", bz, vl, tv, mc);
        end
      end
      if (n < 16 * st) begin
        tests++;
        if (mo !== 4'(n / st)) begin
          fails++;
          $display("FAIL m_out_seq: edge %0d m_out=%0d want %0d", n, mo, n / st);
        end
      end
      tests++;
      if (dn !== (n == last)) begin
        fails++;
        $display("FAIL done_timing: edge %0d done=%b want %b", n, dn, (n == last));
      end
      if (n == last) begin
        r = sbq.pop_front();
        tests++;
        if (vl !== 1'b1 || bz !== 1'b0 || tv !== r.tt || mc !== r.cnt || ff !== r.ff || ps !== r.pass) begin
          fails++;
          $display("FAIL results: valid=%b busy=%b tt=%h cnt=%0d ff=%0d pass=%b want 1 0 %h %0d %0d %b",
                   vl, bz, tv, mc, ff, ps, r.tt, r.cnt, r.ff, r.pass);
        end
      end
    end
    tests++;
    if (vl !== 1'b1 || mc !== model(s, e).cnt) begin
      fails++;
      $display("FAIL results_hold: valid=%b cnt=%0d want 1 %0d", vl, mc, model(s, e).cnt);
    end
  endtask

  task automatic wait_mout(input logic [3:0] target);
    int i = 0;
    while (mo !== target && i < 100) begin
      @(negedge clk);
      i++;
    end
    tests++;
    if (mo !== target) begin
      fails++;
      $display("FAIL wait_m_out: timeout m_out=%0d want %0d", mo, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      tests++;
      if (mo !== 4'd0 || bz !== 1'b0 || dn !== 1'b0 || vl !== 1'b0 || tv !== 16'd0 ||
          mc !== 5'd0 || ff !== 4'd0 || ps !== 1'b0) begin
        fails++;
        $display("FAIL reset_state: dut%0d m=%0d b=%b d=%b v=%b tt=%h c=%0d ff=%0d p=%b want all 0",
                 s, mo, bz, dn, vl, tv, mc, ff, ps);
      end
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pass();
    run_scan(1'b0, 16'h3C00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_mismatch();
    run_scan(1'b0, 16'h3C01, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_settle3();
    run_scan(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    bit seen;
    @(negedge clk);
    sel = 1'b0; expected = 16'h3C00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_mout(4'd7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if (bz !== 1'b0 || mo !== 4'd0 || vl !== 1'b0 || dn !== 1'b0) begin
      fails++;
      $display("FAIL abort_state: busy=%b m_out=%0d valid=%b done=%b want 0 0 0 0", bz, mo, vl, dn);
    end
    tests++;
    if (tv !== 16'd0 || mc !== 5'd0) begin
      fails++;
      $display("FAIL abort_partial: tt=%h cnt=%0d want 0000 0", tv, mc);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dn === 1'b1 || bz === 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL abort_quiet: done/busy seen=%b want 0", seen);
    end
    run_scan(1'b0, 16'h3800, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_abort_idle();
    run_scan(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    sel = 1'b0; expected = 16'h00FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_mout(4'd5);
    tests++;
    if (mc !== 5'd5) begin
      fails++;
      $display("FAIL partial_cnt: cnt=%0d want 5", mc);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (mo !== 4'd0 || bz !== 1'b0 || dn !== 1'b0 || vl !== 1'b0 || tv !== 16'd0 ||
        mc !== 5'd0 || ff !== 4'd0 || ps !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: m=%0d b=%b d=%b v=%b tt=%h c=%0d ff=%0d p=%b want all 0",
               mo, bz, dn, vl, tv, mc, ff, ps);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (bz !== 1'b0 || mo !== 4'd0) begin
      fails++;
      $display("FAIL post_reset_idle: busy=%b m_out=%0d want 0 0", bz, mo);
    end
  endtask

  task automatic test_back_to_back();
    run_scan(1'b0, 16'h0400, 1'b1, 1'b0, 1'b0);
    run_scan(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_settle3();
    test_abort();
    test_start_abort_idle();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
